// File: rtl/trap_controller.sv
// Trap sequencer: saves mepc/mcause/mtval, fetches mtvec (or mepc for MRET)
// and hands the redirect target to the PC mux while stalling the pipeline.
module trap_controller #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      trap_status,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] bad_addr,
    input  logic [XLEN-1:0] csr_read_data,
    output logic            csr_trap_write,
    output logic [11:0]     csr_trap_address,
    output logic [XLEN-1:0] csr_trap_write_data,
    output logic [XLEN-1:0] trap_target,
    output logic            trap_target_valid,
    output logic            trap_done
);

    localparam logic [2:0] TS_NONE             = 3'd0;
    localparam logic [2:0] TS_ECALL            = 3'd1;
    localparam logic [2:0] TS_EBREAK           = 3'd2;
    localparam logic [2:0] TS_MISALIGNED_INSTR = 3'd3;
    localparam logic [2:0] TS_MISALIGNED_LOAD  = 3'd4;
    localparam logic [2:0] TS_MISALIGNED_STORE = 3'd5;
    localparam logic [2:0] TS_ILLEGAL          = 3'd6;
    localparam logic [2:0] TS_MRET             = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        R_MTVEC,
        R_MEPC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   bad_addr_q, bad_addr_d;
    logic [2:0]        cause_q, cause_d;
    logic [XLEN-1:0]   trap_target_q, trap_target_d;

    // Low two bits of any CSR read are discarded so targets stay word aligned.
    logic              unused_read_bits;
    assign unused_read_bits = ^csr_read_data[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            bad_addr_q    <= '0;
            cause_q       <= '0;
            trap_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            bad_addr_q    <= bad_addr_d;
            cause_q       <= cause_d;
            trap_target_q <= trap_target_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        instr_d             = instr_q;
        bad_addr_d          = bad_addr_q;
        cause_d             = cause_q;
        trap_target_d       = trap_target_q;
        csr_trap_write      = 1'b0;
        csr_trap_address    = 12'h000;
        csr_trap_write_data = '0;
        trap_target_valid   = 1'b0;
        trap_done           = 1'b0;

        case (state_q)
            IDLE: begin
                trap_done = (trap_status == TS_NONE);
                if (trap_status != TS_NONE) begin
                    pc_d       = pc;
                    instr_d    = instruction;
                    bad_addr_d = bad_addr;
                    cause_d    = trap_status;
                    state_d    = (trap_status == TS_MRET) ? R_MEPC : W_MEPC;
                end
            end
            W_MEPC: begin
                csr_trap_write      = 1'b1;
                csr_trap_address    = MEPC_ADDR;
                csr_trap_write_data = {pc_q[XLEN-1:2], 2'b00};
                state_d             = W_MCAUSE;
            end
            W_MCAUSE: begin
                csr_trap_write   = 1'b1;
                csr_trap_address = MCAUSE_ADDR;
                // Only synchronous exceptions reach here, so the interrupt bit stays 0.
                case (cause_q)
                    TS_ECALL:            csr_trap_write_data = XLEN'(4'd11);
                    TS_EBREAK:           csr_trap_write_data = XLEN'(4'd3);
                    TS_MISALIGNED_INSTR: csr_trap_write_data = XLEN'(4'd0);
                    TS_MISALIGNED_LOAD:  csr_trap_write_data = XLEN'(4'd4);
                    TS_MISALIGNED_STORE: csr_trap_write_data = XLEN'(4'd6);
                    TS_ILLEGAL:          csr_trap_write_data = XLEN'(4'd2);
                    default:             csr_trap_write_data = '0;
                endcase
                state_d = W_MTVAL;
            end
            W_MTVAL: begin
                csr_trap_write   = 1'b1;
                csr_trap_address = MTVAL_ADDR;
                case (cause_q)
                    TS_MISALIGNED_INSTR,
                    TS_MISALIGNED_LOAD,
                    TS_MISALIGNED_STORE: csr_trap_write_data = bad_addr_q;
                    TS_ILLEGAL:          csr_trap_write_data = XLEN'(instr_q);
                    TS_EBREAK:           csr_trap_write_data = pc_q;
                    default:             csr_trap_write_data = '0;
                endcase
                state_d = R_MTVEC;
            end
            R_MTVEC: begin
                csr_trap_address = MTVEC_ADDR;
                trap_target_d    = {csr_read_data[XLEN-1:2], 2'b00};
                state_d          = DONE;
            end
            R_MEPC: begin
                csr_trap_address = MEPC_ADDR;
                trap_target_d    = {csr_read_data[XLEN-1:2], 2'b00};
                state_d          = DONE;
            end
            DONE: begin
                trap_target_valid = 1'b1;
                trap_done         = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign trap_target = trap_target_q;

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequential responder behind the control unit's trap_done stall input.
- On a trap request from the decode/exception logic, it performs pre-trap CSR bookkeeping through a dedicated CSR write/read port: mepc, mcause and mtval writes, then an mtvec read.
- It then presents a redirect target and releases the stall; for MRET it reads mepc and redirects to it.
- Sits between the exception detector, the CSR file and the PC-next mux.

Parameters:
- XLEN, 32, data/address width.
- MTVEC_ADDR, 12'h305, CSR address of mtvec.
- MEPC_ADDR, 12'h341, CSR address of mepc.
- MCAUSE_ADDR, 12'h342, CSR address of mcause.
- MTVAL_ADDR, 12'h343, CSR address of mtval.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- trap_status  in  3  0 NONE, 1 ECALL, 2 EBREAK, 3 MISALIGNED_INSTR, 4 MISALIGNED_LOAD, 5 MISALIGNED_STORE, 6 ILLEGAL, 7 MRET.
- pc  in  XLEN  PC of the trapping instruction.
- instruction  in  32  raw instruction word.
- bad_addr  in  XLEN  faulting address for misaligned traps.
- csr_read_data  in  XLEN  CSR file combinational read data for csr_trap_address.
- csr_trap_write  out  1  CSR write strobe.
- csr_trap_address  out  12  CSR address for read or write.
- csr_trap_write_data  out  XLEN  CSR write data.
- trap_target  out  XLEN  redirect PC.
- trap_target_valid  out  1  PC mux selects trap_target this cycle.
- trap_done  out  1  low while trap handling is in progress; feeds the control unit's trap_done (pc_stall).

Behaviour:
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC, DONE. Encoding is free.
- Reset (async, reset_n low):
  - state=IDLE.
  - Capture registers, trap_target, csr_trap_address, csr_trap_write_data cleared to 0.
  - csr_trap_write=0, trap_target_valid=0.
- trap_done is combinational: 1 iff (state==IDLE && trap_status==NONE) || state==DONE.
  - It therefore drops in the same cycle a trap is raised, so no instruction commits past the trap.
- IDLE, trap_status!=NONE:
  - Latch pc, instruction, bad_addr, trap_status into capture regs.
  - Go to R_MEPC if MRET, otherwise W_MEPC.
  - All later states use captured values only; inputs need not be held.
- W_MEPC: csr_trap_write=1, address MEPC_ADDR, data=captured pc[XLEN-1:2],2'b00. Next W_MCAUSE.
- W_MCAUSE: csr_trap_write=1, address MCAUSE_ADDR. Next W_MTVAL. Data by cause:
  - ECALL 11, EBREAK 3, MISALIGNED_INSTR 0, MISALIGNED_LOAD 4, MISALIGNED_STORE 6, ILLEGAL 2.
  - Bit XLEN-1 is always 0 (synchronous exceptions only).
- W_MTVAL: csr_trap_write=1, address MTVAL_ADDR. Next R_MTVEC. Data by cause:
  - Misaligned cases: bad_addr.
  - ILLEGAL: instruction.
  - EBREAK: pc.
  - ECALL: 0.
- R_MTVEC: csr_trap_write=0, address MTVEC_ADDR. Register trap_target = {csr_read_data[XLEN-1:2],2'b00} (direct mode only; MODE bits ignored). Next DONE.
- R_MEPC: csr_trap_write=0, address MEPC_ADDR. Register trap_target = {csr_read_data[XLEN-1:2],2'b00}. Next DONE.
- DONE: trap_target_valid=1, trap_done=1 for exactly one cycle. Next IDLE unconditionally.
  - trap_status seen in the following IDLE cycle is treated as a new trap.
- csr_trap_write_data=0 and csr_trap_address=0 in IDLE and DONE; csr_trap_write is asserted only in W_* states.
- Latency from trap_status asserted (IDLE) to trap_target_valid:
  - Exception: 5 cycles (W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, DONE).
  - MRET: 2 cycles (R_MEPC, DONE).
- trap_status changes while the FSM is busy are ignored.
- Reset mid-sequence aborts immediately to IDLE; partially written CSRs are not rolled back.
- Any CSR value read through R_* is masked on its low two bits, so an unaligned mtvec/mepc never produces an unaligned target.

Test Plan:
- Reset with trap_status=0 -> trap_done=1, csr_trap_write=0, trap_target=0, trap_target_valid=0.
- ECALL at pc=0x0000_0100, mtvec reads 0x0000_0800 -> writes in order: 0x341←0x100, 0x342←11, 0x343←0; trap_target=0x800 with trap_target_valid on cycle 5; trap_done low cycles 0–4.
- MISALIGNED_LOAD, bad_addr=0x1003, pc=0x200, mtvec=0x0000_0803 -> mcause 4, mtval 0x1003, trap_target=0x800 (mode bits masked).
- ILLEGAL, instruction=0xFFFF_FFFF -> mtval written 0xFFFF_FFFF; trap_status deasserted after cycle 0 does not change the sequence.
- MRET with mepc=0x0000_0104 -> no CSR writes; trap_target=0x104 valid on cycle 2; next IDLE with NONE gives trap_done=1.
- reset_n pulsed low during W_MCAUSE -> immediate IDLE, csr_trap_write=0; a fresh ECALL afterward completes the full 5-cycle sequence.
